// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage and the register file.
package wb_regfile_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned COUNT_W     = 32;

    typedef logic [REG_IDX_W-1:0] reg_index;

    localparam reg_index ZERO_REG = reg_index'(0);

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback data select: load data for loads, ALU result otherwise.
module wb_mux #(
    parameter int unsigned DATA_WIDTH = wb_regfile_pkg::DATA_WIDTH
) (
    input  logic                  MEMORY_READ_input,
    input  logic [DATA_WIDTH-1:0] result_input,
    input  logic [DATA_WIDTH-1:0] loadvalue_input,
    output logic [DATA_WIDTH-1:0] write_data
);

    assign write_data = MEMORY_READ_input ? loadvalue_input : result_input;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with writeback port, two combinational read ports
// and a saturating retired-write counter. Define WB_REGFILE_BYPASS_EN for write-to-read bypass.
module wb_regfile #(
    parameter int unsigned DATA_WIDTH = wb_regfile_pkg::DATA_WIDTH,
    parameter int unsigned REG_COUNT  = 32
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  WRITEBACK_input,
    input  logic                                  MEMORY_READ_input,
    input  wb_regfile_pkg::reg_index              destination_input,
    input  logic [DATA_WIDTH-1:0]                 result_input,
    input  logic [DATA_WIDTH-1:0]                 loadvalue_input,
    input  wb_regfile_pkg::reg_index              read_address_1,
    input  wb_regfile_pkg::reg_index              read_address_2,
    output logic [DATA_WIDTH-1:0]                 read_data_1,
    output logic [DATA_WIDTH-1:0]                 read_data_2,
    output logic [wb_regfile_pkg::COUNT_W-1:0]    writeback_count
);

    localparam int unsigned COUNT_W = wb_regfile_pkg::COUNT_W;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [COUNT_W-1:0]    count_q;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_en_c;

    wb_mux #(.DATA_WIDTH(DATA_WIDTH)) u_wb_mux (
        .MEMORY_READ_input (MEMORY_READ_input),
        .result_input      (result_input),
        .loadvalue_input   (loadvalue_input),
        .write_data        (write_data)
    );

    // Register 0 is hardwired; writes to it are not retired.
    assign write_en_c = WRITEBACK_input
                     && (destination_input != wb_regfile_pkg::ZERO_REG)
                     && (32'(destination_input) < REG_COUNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en_c) begin
            regs_q[destination_input] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (write_en_c && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign writeback_count = count_q;

    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if ((read_address_1 != wb_regfile_pkg::ZERO_REG) && (32'(read_address_1) < REG_COUNT)) begin
            read_data_1 = regs_q[read_address_1];
        end
        if ((read_address_2 != wb_regfile_pkg::ZERO_REG) && (32'(read_address_2) < REG_COUNT)) begin
            read_data_2 = regs_q[read_address_2];
        end
`ifdef WB_REGFILE_BYPASS_EN
        // Same-cycle writeback is visible to decode reads.
        if (write_en_c && (destination_input == read_address_1)) begin
            read_data_1 = write_data;
        end
        if (write_en_c && (destination_input == read_address_2)) begin
            read_data_2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile (default build or WB_REGFILE_BYPASS_EN build).
module tb_wb_regfile;

    logic        clock;
    logic        reset_n;
    logic        WRITEBACK_input;
    logic        MEMORY_READ_input;
    logic [4:0]  destination_input;
    logic [31:0] result_input;
    logic [31:0] loadvalue_input;
    logic [4:0]  read_address_1;
    logic [4:0]  read_address_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] writeback_count;

    int unsigned total_checks;
    int unsigned passed_checks;
    logic [31:0] exp_q [$];
    logic [31:0] exp_count;

    wb_regfile dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .WRITEBACK_input   (WRITEBACK_input),
        .MEMORY_READ_input (MEMORY_READ_input),
        .destination_input (destination_input),
        .result_input      (result_input),
        .loadvalue_input   (loadvalue_input),
        .read_address_1    (read_address_1),
        .read_address_2    (read_address_2),
        .read_data_1       (read_data_1),
        .read_data_2       (read_data_2),
        .writeback_count   (writeback_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        total_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h, no expected value queued", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) passed_checks++;
            else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one writeback, clock it, then idle the port.
    task automatic do_write(input logic mr, input logic [4:0] dest,
                            input logic [31:0] res, input logic [31:0] ld);
        @(negedge clock);
        WRITEBACK_input   = 1'b1;
        MEMORY_READ_input = mr;
        destination_input = dest;
        result_input      = res;
        loadvalue_input   = ld;
        @(posedge clock);
        #1;
        WRITEBACK_input   = 1'b0;
    endtask

    initial begin
        total_checks      = 0;
        passed_checks     = 0;
        exp_count         = '0;
        reset_n           = 1'b0;
        WRITEBACK_input   = 1'b0;
        MEMORY_READ_input = 1'b0;
        destination_input = '0;
        result_input      = '0;
        loadvalue_input   = '0;
        read_address_1    = 5'd5;
        read_address_2    = 5'd9;
        #3;
        push_exp(32'h0); check("reset_rd1", read_data_1);
        push_exp(32'h0); check("reset_count", writeback_count);

        // Write attempted while reset held is lost.
        do_write(1'b0, 5'd9, 32'hAAAA_AAAA, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        push_exp(32'h0); check("write_in_reset_reg9", read_data_2);
        push_exp(32'h0); check("write_in_reset_count", writeback_count);

        // ALU write.
        do_write(1'b0, 5'd5, 32'h1234_5678, 32'h0);
        exp_count++;
        read_address_1 = 5'd5;
        #1;
        push_exp(32'h1234_5678); check("alu_write_reg5", read_data_1);
        push_exp(exp_count);     check("alu_write_count", writeback_count);

        // Load write.
        do_write(1'b1, 5'd7, 32'h0000_0001, 32'hDEAD_BEEF);
        exp_count++;
        read_address_2 = 5'd7;
        #1;
        push_exp(32'hDEAD_BEEF); check("load_write_reg7", read_data_2);
        push_exp(exp_count);     check("load_write_count", writeback_count);

        // Zero register write is discarded.
        do_write(1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_address_1 = 5'd0;
        read_address_2 = 5'd0;
        #1;
        push_exp(32'h0);     check("zero_reg_rd1", read_data_1);
        push_exp(32'h0);     check("zero_reg_rd2", read_data_2);
        push_exp(exp_count); check("zero_reg_count", writeback_count);

        // Writeback disabled: nothing changes.
        @(negedge clock);
        MEMORY_READ_input = 1'b1;
        destination_input = 5'd5;
        result_input      = 32'hBAD0_BAD0;
        loadvalue_input   = 32'hBAD1_BAD1;
        @(posedge clock);
        #1;
        read_address_1 = 5'd5;
        #1;
        push_exp(32'h1234_5678); check("wb_off_reg5", read_data_1);
        push_exp(exp_count);     check("wb_off_count", writeback_count);

        // Identical addresses on both ports.
        read_address_1 = 5'd7;
        read_address_2 = 5'd7;
        #1;
        push_exp(32'hDEAD_BEEF); check("same_addr_rd1", read_data_1);
        push_exp(32'hDEAD_BEEF); check("same_addr_rd2", read_data_2);

        // Same-cycle read/write hazard on reg3.
        do_write(1'b0, 5'd3, 32'h11, 32'h0);
        exp_count++;
        @(negedge clock);
        WRITEBACK_input   = 1'b1;
        MEMORY_READ_input = 1'b0;
        destination_input = 5'd3;
        result_input      = 32'h22;
        read_address_1    = 5'd5;
        read_address_2    = 5'd3;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        push_exp(32'h22);
`else
        push_exp(32'h11);
`endif
        check("hazard_same_cycle", read_data_2);
        push_exp(32'h1234_5678); check("hazard_other_port", read_data_1);
        @(posedge clock);
        #1;
        WRITEBACK_input = 1'b0;
        exp_count++;
        #1;
        push_exp(32'h22);    check("hazard_next_cycle", read_data_2);
        push_exp(exp_count); check("hazard_count", writeback_count);

        // Asynchronous reset mid-cycle, no clock edge.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        exp_count = '0;
        for (int a = 0; a < 32; a++) begin
            read_address_1 = 5'(a);
            read_address_2 = 5'(31 - a);
            #0.1;
            push_exp(32'h0); check($sformatf("async_reset_rd1_%0d", a), read_data_1);
            push_exp(32'h0); check($sformatf("async_reset_rd2_%0d", 31 - a), read_data_2);
        end
        push_exp(exp_count); check("async_reset_count", writeback_count);
        @(negedge clock);
        reset_n = 1'b1;

        // Counter saturation from 0xFFFF_FFFE after three writes.
        @(negedge clock);
        force dut.count_q = 32'hFFFF_FFFE;
        do_write(1'b0, 5'd1, 32'h1, 32'h0);
        release dut.count_q;
        do_write(1'b0, 5'd2, 32'h2, 32'h0);
        do_write(1'b0, 5'd4, 32'h4, 32'h0);
        #1;
        push_exp(32'hFFFF_FFFF); check("saturate_count", writeback_count);
        read_address_1 = 5'd4;
        #1;
        push_exp(32'h4); check("saturate_reg4", read_data_1);

        if (exp_q.size() != 0) begin
            total_checks++;
            $error("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and data-path width in bits.
REQ-002 Parameter REG_COUNT, default 32, number of architectural registers; address width is 5 bits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 WRITEBACK_input  input  1  writeback enable from the MEM/WB pipeline register.
REQ-006 MEMORY_READ_input  input  1  1 = write loadvalue_input, 0 = write result_input.
REQ-007 destination_input  input  5  destination register index.
REQ-008 result_input  input  DATA_WIDTH  ALU result from the MEM/WB pipeline register.
REQ-009 loadvalue_input  input  DATA_WIDTH  memory load data from the MEM/WB pipeline register.
REQ-010 read_address_1, read_address_2  input  5 each  decode-stage source register indices.
REQ-011 read_data_1, read_data_2  output  DATA_WIDTH each  source operand values.
REQ-012 writeback_count  output  32  count of retired register writes.

Function
REQ-013 Write data SHALL be loadvalue_input when MEMORY_READ_input=1, else result_input.
REQ-014 On a rising clock edge with WRITEBACK_input=1 and destination_input!=0, the register at destination_input SHALL take the write data.
REQ-015 Register 0 SHALL always read 0; writes to it SHALL be discarded and SHALL NOT increment writeback_count.
REQ-016 Reads SHALL be combinational: read_data_n = register[read_address_n], with no clock latency.
REQ-017 A write and a read to the same register in the same cycle: without bypass the read SHALL return the old value; bypass behaviour is defined under Configuration.
REQ-018 Both read ports SHALL work independently; identical addresses on both ports SHALL return identical data.
REQ-019 writeback_count SHALL increment by 1 on each edge where a write per REQ-014 occurs, and SHALL saturate at 0xFFFFFFFF.
REQ-020 WRITEBACK_input=0 SHALL leave every register and writeback_count unchanged, whatever the other inputs are.

Reset
REQ-021 When reset_n=0, all registers and writeback_count SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-022 A write coinciding with an asserted reset_n SHALL be lost; the first write SHALL occur on the first rising edge after reset_n deasserts.

Configuration
REQ-023 Macro WB_REGFILE_BYPASS_EN defined: when WRITEBACK_input=1, destination_input!=0 and equal to read_address_n, read_data_n SHALL return the current write data in the same cycle.
REQ-024 Macro undefined: no bypass path; REQ-017 old-value behaviour SHALL apply, and the pipeline resolves the hazard by forwarding or stalling.

Structure
REQ-025 The shared pipeline package SHALL hold DATA_WIDTH, the 5-bit register-index width, the zero-register index constant, and the reg_index type used by wb_regfile and the pipeline registers.
REQ-026 One sub-module, wb_mux, SHALL implement the REQ-013 result/load selection; the storage array and counter SHALL stay in wb_regfile.

Verification
REQ-027 Reset: reset_n=0 mid-simulation, no clock edge -> read_data_1/2=0 for every address and writeback_count=0.
REQ-028 ALU write: WRITEBACK=1, MEMORY_READ=0, dest=5, result=0x1234_5678; read_address_1=5 on the next cycle -> 0x1234_5678 and writeback_count=1.
REQ-029 Load write: WRITEBACK=1, MEMORY_READ=1, dest=7, loadvalue=0xDEAD_BEEF, result=0x1 -> reg7=0xDEAD_BEEF.
REQ-030 Zero register: WRITEBACK=1, dest=0, result=0xFFFF_FFFF -> read of reg0=0 and writeback_count unchanged.
REQ-031 Same-cycle hazard: reg3=0x11, write 0x22 to reg3 with read_address_2=3 in the same cycle -> 0x22 with WB_REGFILE_BYPASS_EN defined, 0x11 without it; both builds read 0x22 on the next cycle.
REQ-032 Saturation: force writeback_count to 0xFFFF_FFFE, perform 3 writes -> writeback_count=0xFFFF_FFFF.
